// File: rtl/shift_cmd_queue.sv
// Command FIFO and registered result stage in front of an 8-bit barrel shifter.
// Optional SHQ_STATS_EN adds done_cnt (wrapping) and drop_cnt (saturating) counters.
module shift_cmd_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [AMT_W-1:0]         in_amt,
  input  logic                     in_sel,
  output logic [DATA_W-1:0]        sh_data_in,
  output logic [AMT_W-1:0]         sh_amt,
  output logic                     sh_sel,
  input  logic [DATA_W-1:0]        sh_data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level
`ifdef SHQ_STATS_EN
  ,
  output logic [15:0]              done_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AMT_W-1:0]  mem_amt  [DEPTH];
  logic              mem_sel  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          load;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign load     = !empty && (!out_valid || out_ready);

  // Head is forced to zero when empty so the shifter never sees stale entries.
  assign sh_data_in = empty ? '0 : mem_data[rd_ptr];
  assign sh_amt     = empty ? '0 : mem_amt[rd_ptr];
  assign sh_sel     = empty ? 1'b0 : mem_sel[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_amt[wr_ptr]  <= in_amt;
      mem_sel[wr_ptr]  <= in_sel;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      case ({push, load})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sh_data_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_valid && out_ready) done_cnt <= done_cnt + 16'd1;
      if (in_valid && full && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based reference model (SHQ_STATS_EN aware).
module tb_shift_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_amt = '0;
  logic       in_sel = 1'b0;
  logic [7:0] sh_data_in;
  logic [2:0] sh_amt;
  logic       sh_sel;
  logic [7:0] sh_data_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] level;
`ifdef SHQ_STATS_EN
  logic [15:0] done_cnt;
  logic [15:0] drop_cnt;
`endif

  shift_cmd_queue #(.DEPTH(DEPTH), .DATA_W(8), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_sel(in_sel),
    .sh_data_in(sh_data_in), .sh_amt(sh_amt), .sh_sel(sh_sel),
    .sh_data_out(sh_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
`ifdef SHQ_STATS_EN
    , .done_cnt(done_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Combinational barrel shifter the queue drives.
  always_comb begin
    sh_data_out = '0;
    for (int i = 0; i < 8; i++) begin
      if (sh_sel) sh_data_out[i] = sh_data_in[(i + int'(sh_amt)) % 8];
      else        sh_data_out[(i + int'(sh_amt)) % 8] = sh_data_in[i];
    end
  end

  typedef struct {
    logic       sel;
    logic [2:0] amt;
    logic [7:0] data;
  } cmd_t;

  typedef struct {
    logic       sel;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  cmd_t       mq[$];
  logic       m_valid;
  logic [7:0] m_data;
  int         m_done;
  int         m_drop;
  bit         last_push;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [7:0] rot(input logic s, input logic [2:0] a, input logic [7:0] d);
    logic [15:0] t;
    t = s ? ({d, d} >> a) : ({d, d} << a);
    return s ? t[7:0] : t[15:8];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("level", 32'(level), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("sh_data_in", 32'(sh_data_in), (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
    chk("sh_amt", 32'(sh_amt), (mq.size() != 0) ? 32'(mq[0].amt) : 32'd0);
    chk("sh_sel", 32'(sh_sel), (mq.size() != 0) ? 32'(mq[0].sel) : 32'd0);
`ifdef SHQ_STATS_EN
    chk("done_cnt", 32'(done_cnt), 32'(m_done));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  task automatic model_clear();
    mq.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_done  = 0;
    m_drop  = 0;
  endtask

  // One clock: model decides from pre-edge state, updates after the edge, then compares.
  task automatic step();
    bit   push, load, done_hs, drop;
    cmd_t c;
    push    = in_valid && (mq.size() < DEPTH);
    load    = (mq.size() != 0) && (!m_valid || out_ready);
    done_hs = m_valid && out_ready;
    drop    = in_valid && (mq.size() >= DEPTH);
    c.sel = in_sel; c.amt = in_amt; c.data = in_data;
    @(posedge clk);
    #1;
    if (load) begin
      m_data  = rot(mq[0].sel, mq[0].amt, mq[0].data);
      m_valid = 1'b1;
      void'(mq.pop_front());
    end else if (done_hs) begin
      m_valid = 1'b0;
    end
    if (push) mq.push_back(c);
    if (done_hs) m_done = (m_done + 1) % 65536;
    if (drop && m_drop < 65535) m_drop++;
    last_push = push;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic drive(input logic s, input logic [2:0] a, input logic [7:0] d);
    in_valid = 1'b1; in_sel = s; in_amt = a; in_data = d;
  endtask

  task automatic drain_all();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && (mq.size() != 0 || m_valid); i++) step();
    chk("drain_done", 32'(mq.size() != 0 || m_valid), 32'd0);
  endtask

  vec_t tbl[8];
  cmd_t stall_cmds[6];

  initial begin
    tbl[0] = '{1'b1, 3'd1, 8'b10110110, 8'b01011011};
    tbl[1] = '{1'b1, 3'd4, 8'b11110000, 8'b00001111};
    tbl[2] = '{1'b0, 3'd2, 8'b10001110, 8'b00111010};
    tbl[3] = '{1'b0, 3'd7, 8'b00000001, 8'b10000000};
    tbl[4] = '{1'b0, 3'd0, 8'b10110110, 8'b10110110};
    tbl[5] = '{1'b1, 3'd1, 8'b00000001, 8'b10000000};
    tbl[6] = '{1'b0, 3'd3, 8'b11000011, 8'b00011110};
    tbl[7] = '{1'b1, 3'd7, 8'b10000000, 8'b00000001};
    stall_cmds[0] = '{1'b1, 3'd1, 8'hB6};
    stall_cmds[1] = '{1'b0, 3'd3, 8'h5A};
    stall_cmds[2] = '{1'b1, 3'd5, 8'hC3};
    stall_cmds[3] = '{1'b0, 3'd1, 8'h81};
    stall_cmds[4] = '{1'b1, 3'd2, 8'h0F};
    stall_cmds[5] = '{1'b0, 3'd6, 8'hE7};

    model_clear();
    #2;
    check_all();
    #10;
    rst_n = 1'b1;

    // Single commands from the table: one-cycle latency, level returns to 0.
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].sel, tbl[v].amt, tbl[v].data);
      step();
      in_valid = 1'b0;
      step();
      chk($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_data", v), 32'(out_data), 32'(tbl[v].exp));
      chk($sformatf("tbl%0d_level", v), 32'(level), 32'd0);
      step();
    end

    // Back-to-back pushes emerge on consecutive cycles.
    drive(1'b1, 3'd4, 8'b11110000); step();
    drive(1'b0, 3'd2, 8'b10001110); step();
    chk("b2b_0", 32'(out_data), 32'b00001111);
    drive(1'b0, 3'd7, 8'b00000001); step();
    chk("b2b_1", 32'(out_data), 32'b00111010);
    in_valid = 1'b0; step();
    chk("b2b_2", 32'(out_data), 32'b10000000);
    chk("b2b_2v", 32'(out_valid), 32'd1);
    step();

    // Fill under backpressure; sixth command held while full.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(stall_cmds[k].sel, stall_cmds[k].amt, stall_cmds[k].data);
      step();
      chk($sformatf("fill%0d_acc", k), 32'(last_push), 32'd1);
    end
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(stall_cmds[5].sel, stall_cmds[5].amt, stall_cmds[5].data);
    step();
    chk("held_level", 32'(level), 32'd4);
    chk("stall_data", 32'(out_data), 32'(rot(1'b1, 3'd1, 8'hB6)));
    out_ready = 1'b1;
    step();
    chk("drain1_level", 32'(level), 32'd3);
    chk("drain1_ready", 32'(in_ready), 32'd1);
    step();
    chk("sixth_acc", 32'(last_push), 32'd1);
    chk("sixth_level", 32'(level), 32'd3);
    drain_all();

    // Empty queue with out_ready toggling.
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      out_ready = k[0];
      step();
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_sh", 32'({sh_sel, sh_amt, sh_data_in}), 32'd0);
    end

    // Reset with level 3 and a pending result.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(stall_cmds[k].sel, stall_cmds[k].amt, stall_cmds[k].data);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 8'b10110110); step();
    in_valid = 1'b0; step();
    chk("post_rst_data", 32'(out_data), 32'b01011011);
    step();

`ifdef SHQ_STATS_EN
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(stall_cmds[k].sel, stall_cmds[k].amt, stall_cmds[k].data);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(stall_cmds[k].sel, stall_cmds[k].amt, stall_cmds[k].data);
      step();
    end
    drive(stall_cmds[5].sel, stall_cmds[5].amt, stall_cmds[5].data);
    step(); step();
    in_valid = 1'b0;
    chk("stats_done", 32'(done_cnt), 32'd3);
    chk("stats_drop", 32'(drop_cnt), 32'd2);
    do_reset();
    chk("stats_rst", 32'({done_cnt, drop_cnt}), 32'd0);
`endif

    // Random traffic; producer holds a refused command.
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 9) < 6);
        in_sel   = 1'($urandom);
        in_amt   = 3'($urandom);
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_cmd_queue.md
Name: shift_cmd_queue

Overview:
- Upstream command stage for the 8-bit barrel shifter (rotate left/right by 0-7).
- Buffers rotate commands {sel, amt, data} in a small FIFO and drives the shifter inputs from the FIFO head.
- Captures the shifter's combinational result into a registered output stage with a valid/ready handshake.
- Decouples the producer of rotate requests from the consumer of rotated bytes.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >= 2
DATA_W, 8, data width; fixed to the shifter width
AMT_W, 3, rotate-amount width; equals log2(DATA_W)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command present
in_ready  output  1  queue can accept (= !full)
in_data  input  DATA_W  byte to rotate
in_amt  input  AMT_W  rotate amount
in_sel  input  1  1 = rotate right, 0 = rotate left
sh_data_in  output  DATA_W  to shifter data_in (FIFO head)
sh_amt  output  AMT_W  to shifter amt
sh_sel  output  1  to shifter sel
sh_data_out  input  DATA_W  from shifter data_out (combinational)
out_valid  output  1  result register holds a result
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  registered rotated byte
level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync-released use): wr_ptr, rd_ptr and level = 0; out_valid = 0; out_data = 0; in_ready = 1.
- Enqueue: on in_valid && in_ready, write {in_sel, in_amt, in_data} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Head drive:
  - When not empty, sh_* = head entry, purely combinational from FIFO storage.
  - When empty, sh_data_in = 0, sh_amt = 0, sh_sel = 0.
- Load condition: load = !empty && (!out_valid || out_ready).
  - On load: out_data <= sh_data_out, out_valid <= 1, rd_ptr advances with wrap.
- Drain: out_valid && out_ready && !load -> out_valid <= 0; out_data holds its last value.
- Latency: command accepted at edge E0 into an empty queue with a free output -> out_valid high after edge E1 (one cycle).
- Throughput: one result per cycle when out_ready is held high.
- Occupancy: level +1 on enqueue only, -1 on load only, unchanged when both happen in the same cycle.
- Full (level == DEPTH): in_ready = 0; no write, no bypass; a same-cycle load frees space for the next cycle only.
- Empty: no load; out_valid still drains normally.
- Backpressure: out_ready = 0 with out_valid = 1 -> out_data and the FIFO head are held stable.
- Ordering: strict FIFO; results leave in acceptance order.
- in_valid while full: the command is not taken; the producer must hold it.
- Reset mid-operation: all queued commands and any pending result are discarded immediately; outputs return to reset values.
- Arithmetic: no width conversion; out_data is exactly the DATA_W-bit shifter output.

Optional Feature:
- Macro SHQ_STATS_EN.
- When defined:
  - Adds output done_cnt [15:0], reset 0, +1 on each out_valid && out_ready, wraps 65535 -> 0.
  - Adds output drop_cnt [15:0], reset 0, +1 on each cycle with in_valid && !in_ready, saturating at 65535.
- When undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset then push sel=1, data=10110110, amt=1 with out_ready=1 -> out_valid one cycle later, out_data=01011011, level back to 0.
- Back-to-back pushes (sel=1,11110000,amt=4), (sel=0,10001110,amt=2), (sel=0,00000001,amt=7) with out_ready=1 -> outputs 00001111, 00111010, 10000000 on consecutive cycles, in order.
- out_ready=0, push 6 commands (DEPTH=4):
  - First 5 accepted (1 in output register, 4 queued); level=4, in_ready=0; the 6th is held.
  - Raise out_ready -> 6th accepted the cycle after the first drain.
  - All results emerge in order, with out_data stable while stalled.
- Empty queue with out_ready toggling -> sh_data_in/sh_amt/sh_sel = 0, out_valid stays 0, level = 0.
- Assert rst_n=0 with level=3 and out_valid=1 -> level=0, out_valid=0, out_data=0 immediately; a post-reset push of (1,10110110,1) yields 01011011.
- SHQ_STATS_EN: 3 results consumed plus 2 stalled-push cycles while full -> done_cnt=3, drop_cnt=2; reset -> both 0.
